// File: rtl/param_queue.sv
// Parametrised circular-buffer FIFO for the 10 kHz domain with registered output and valid strobe.
// Define PARAM_QUEUE_ERR_FLAGS_EN to build the sticky overflow/underflow error flags.
module param_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_10khz,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enqueue_in,
  input  logic             dequeue_in,
  input  logic             err_clear_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid_out,
  output logic [CNT_W-1:0] len_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             overflow_out,
  output logic             underflow_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(DEPTH - 1);
  localparam logic [PtrW-1:0]  PtrOne  = PtrW'(1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             deq_acc, enq_acc;

  always_comb begin
    deq_acc = dequeue_in && (count_q != '0);
    // A dequeue in the same cycle frees a slot, so a full queue can still accept.
    enq_acc = enqueue_in && ((count_q != CntMax) || deq_acc);

    count_d = count_q;
    if (enq_acc && !deq_acc) begin
      count_d = count_q + CntOne;
    end else if (!enq_acc && deq_acc) begin
      count_d = count_q - CntOne;
    end

    wr_ptr_d = wr_ptr_q;
    if (enq_acc) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
    end

    rd_ptr_d     = rd_ptr_q;
    data_out_d   = data_out_q;
    data_valid_d = deq_acc;
    if (deq_acc) begin
      rd_ptr_d   = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
      data_out_d = mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_10khz or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable until rewritten.
  always_ff @(posedge clk_10khz) begin
    if (enq_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out       = data_out_q;
  assign data_valid_out = data_valid_q;
  assign len_out        = count_q;
  assign full_out       = (count_q == CntMax);
  assign empty_out      = (count_q == '0);

`ifdef PARAM_QUEUE_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d  = (overflow_q && !err_clear_in) || (enqueue_in && !enq_acc);
    underflow_d = (underflow_q && !err_clear_in) || (dequeue_in && !deq_acc);
  end

  always_ff @(posedge clk_10khz or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_out  = overflow_q;
  assign underflow_out = underflow_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear_in;
  assign overflow_out     = 1'b0;
  assign underflow_out    = 1'b0;
`endif

endmodule

// File: tb/tb_param_queue.sv
// Directed self-checking bench for param_queue (WIDTH=8, DEPTH=8).
`timescale 1us/1ns
module tb_param_queue;

`ifdef PARAM_QUEUE_ERR_FLAGS_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic       clk_10khz;
  logic       reset;
  logic [7:0] data_in;
  logic       enqueue_in;
  logic       dequeue_in;
  logic       err_clear_in;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic [3:0] len_out;
  logic       full_out;
  logic       empty_out;
  logic       overflow_out;
  logic       underflow_out;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  param_queue #(
    .WIDTH(8),
    .DEPTH(8)
  ) dut (
    .clk_10khz      (clk_10khz),
    .reset          (reset),
    .data_in        (data_in),
    .enqueue_in     (enqueue_in),
    .dequeue_in     (dequeue_in),
    .err_clear_in   (err_clear_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .len_out        (len_out),
    .full_out       (full_out),
    .empty_out      (empty_out),
    .overflow_out   (overflow_out),
    .underflow_out  (underflow_out)
  );

  initial clk_10khz = 1'b0;
  always #50 clk_10khz = ~clk_10khz;

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: simulation did not complete in time");
      $finish;
    end
  end

`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end \
  end

  // Apply requests, let one rising edge sample them, then settle before checking.
  task automatic cyc(input logic enq, input logic deq, input logic [7:0] din, input logic clr);
    enqueue_in   = enq;
    dequeue_in   = deq;
    data_in      = din;
    err_clear_in = clr;
    @(posedge clk_10khz);
    #1;
  endtask

  task automatic fill_11_88();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'((i + 1) * 17), 1'b0);
    end
  endtask

  logic [7:0] exp_d;
  logic [7:0] model_q[$];
  logic [7:0] next_d;

  initial begin
    reset        = 1'b1;
    enqueue_in   = 1'b0;
    dequeue_in   = 1'b0;
    err_clear_in = 1'b0;
    data_in      = 8'h00;
    #20;
    checks++;
    if (len_out !== 4'd0 || empty_out !== 1'b1 || full_out !== 1'b0 ||
        data_out !== 8'h00 || data_valid_out !== 1'b0 ||
        overflow_out !== 1'b0 || underflow_out !== 1'b0) begin
      errors++;
      $error("FAIL reset state: len=%0h empty=%0b full=%0b data=%0h valid=%0b ovf=%0b unf=%0b",
             len_out, empty_out, full_out, data_out, data_valid_out, overflow_out,
             underflow_out);
    end
    `CHK("rst_len", len_out, 4'd0)
    `CHK("rst_empty", empty_out, 1'b1)
    `CHK("rst_full", full_out, 1'b0)
    `CHK("rst_data", data_out, 8'h00)
    `CHK("rst_valid", data_valid_out, 1'b0)
    `CHK("rst_ovf", overflow_out, 1'b0)
    `CHK("rst_unf", underflow_out, 1'b0)
    @(negedge clk_10khz);
    reset = 1'b0;

    // Fill and drain
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'((i + 1) * 17), 1'b0);
      checks++;
      if (len_out !== 4'(i + 1)) begin
        errors++;
        $error("FAIL fill_len_x observed=%0h expected=%0h", len_out, 4'(i + 1));
      end
      `CHK("fill_len", len_out, 4'(i + 1))
      `CHK("fill_full", full_out, (i == 7))
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      exp_d = 8'((i + 1) * 17);
      checks++;
      if (data_out !== exp_d || data_valid_out !== 1'b1) begin
        errors++;
        $error("FAIL drain_x observed=%0h/%0b expected=%0h/1", data_out, data_valid_out, exp_d);
      end
      `CHK("drain_data", data_out, exp_d)
      `CHK("drain_valid", data_valid_out, 1'b1)
      `CHK("drain_len", len_out, 4'(7 - i))
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    `CHK("drain_valid_off", data_valid_out, 1'b0)
    `CHK("drain_empty", empty_out, 1'b1)
    `CHK("drain_ovf", overflow_out, 1'b0)
    `CHK("drain_unf", underflow_out, 1'b0)

    // Full with simultaneous enqueue and dequeue
    fill_11_88();
    `CHK("full2_full", full_out, 1'b1)
    cyc(1'b1, 1'b1, 8'h99, 1'b0);
    `CHK("full_both_data", data_out, 8'h11)
    `CHK("full_both_valid", data_valid_out, 1'b1)
    `CHK("full_both_len", len_out, 4'd8)
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      exp_d = (i == 7) ? 8'h99 : 8'((i + 2) * 17);
      `CHK("full_both_drain", data_out, exp_d)
    end
    `CHK("full_both_ovf", overflow_out, 1'b0)
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Overflow and sticky clear
    fill_11_88();
    cyc(1'b1, 1'b0, 8'hAA, 1'b0);
    `CHK("ovf_len", len_out, 4'd8)
    `CHK("ovf_set", overflow_out, ErrEn)
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    `CHK("ovf_hold", overflow_out, ErrEn)
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    `CHK("ovf_clear", overflow_out, 1'b0)
    cyc(1'b1, 1'b0, 8'hBB, 1'b1);
    `CHK("ovf_set_wins", overflow_out, ErrEn)
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    `CHK("ovf_clear2", overflow_out, 1'b0)
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      exp_d = 8'((i + 1) * 17);
      `CHK("ovf_contents", data_out, exp_d)
    end
    `CHK("ovf_unf_none", underflow_out, 1'b0)

    // Empty with simultaneous enqueue and dequeue
    cyc(1'b1, 1'b1, 8'h5A, 1'b0);
    `CHK("empty_both_len", len_out, 4'd1)
    `CHK("empty_both_valid", data_valid_out, 1'b0)
    `CHK("empty_both_data", data_out, 8'h88)
    `CHK("empty_both_unf", underflow_out, ErrEn)
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    `CHK("empty_both_deq", data_out, 8'h5A)
    `CHK("empty_both_deq_v", data_valid_out, 1'b1)
    `CHK("empty_both_deq_len", len_out, 4'd0)
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    `CHK("unf_clear", underflow_out, 1'b0)

    // Wrap-around at occupancy 3/4
    next_d = 8'h01;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, next_d, 1'b0);
      model_q.push_back(next_d);
      next_d = next_d + 8'h01;
    end
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        cyc(1'b1, 1'b0, next_d, 1'b0);
        model_q.push_back(next_d);
        next_d = next_d + 8'h01;
        `CHK("wrap_len4", len_out, 4'd4)
      end else begin
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        exp_d = model_q.pop_front();
        checks++;
        if (data_out !== exp_d) begin
          errors++;
          $error("FAIL wrap_data_x observed=%0h expected=%0h", data_out, exp_d);
        end
        `CHK("wrap_data", data_out, exp_d)
        `CHK("wrap_len3", len_out, 4'd3)
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      exp_d = model_q.pop_front();
      `CHK("wrap_tail", data_out, exp_d)
    end
    `CHK("wrap_empty", empty_out, 1'b1)

    // Asynchronous reset mid-operation
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    `CHK("pre_rst_len", len_out, 4'd5)
    `CHK("pre_rst_data", data_out, 8'h30)
    #20;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    reset      = 1'b1;
    #1;
    `CHK("mid_rst_len", len_out, 4'd0)
    `CHK("mid_rst_empty", empty_out, 1'b1)
    `CHK("mid_rst_full", full_out, 1'b0)
    `CHK("mid_rst_data", data_out, 8'h00)
    `CHK("mid_rst_valid", data_valid_out, 1'b0)
    #5;
    reset = 1'b0;
    cyc(1'b1, 1'b0, 8'h01, 1'b0);
    `CHK("post_rst_len", len_out, 4'd1)
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    `CHK("post_rst_data", data_out, 8'h01)
    `CHK("post_rst_valid", data_valid_out, 1'b1)
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    `CHK("post_rst_empty", empty_out, 1'b1)

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors != 0) begin
      $error("FAIL summary: %0d of %0d checks failed", errors, checks);
    end
    $finish;
  end

endmodule
